// File: rtl/fpu_issue_buffer.sv
// fpu_issue_buffer: in-order request FIFO with a RAW/WAW/WAR scoreboard gating issue to a multi-cycle FPU core.
module fpu_issue_buffer #(
    parameter int REG_AW       = 5,
    parameter int OP_W         = 6,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int IW = $clog2(MAX_INFLIGHT) + 1,
    localparam int NR = 2 ** REG_AW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_AW-1:0] req_x1,
    input  logic [REG_AW-1:0] req_x2,
    input  logic [REG_AW-1:0] req_y,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [REG_AW-1:0] core_x1,
    output logic [REG_AW-1:0] core_x2,
    output logic [REG_AW-1:0] core_y,
    output logic [OP_W-1:0]   core_op,
    output logic [DATA_W-1:0] core_data,
    input  logic              cpl_valid,
    input  logic [REG_AW-1:0] cpl_y,
    output logic [CW-1:0]     count,
    output logic [IW-1:0]     inflight,
    output logic [NR-1:0]     pend_map,
    output logic              err_cpl
);
    logic [REG_AW-1:0] x1_q [DEPTH];
    logic [REG_AW-1:0] x2_q [DEPTH];
    logic [REG_AW-1:0] y_q  [DEPTH];
    logic [OP_W-1:0]   op_q [DEPTH];
    logic [DATA_W-1:0] dat_q[DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     infl_q, infl_d;
    logic [NR-1:0]     pend_q, pend_d;
    logic              err_q, err_d;
    logic              push, pop, hazard, cpl_ok;

    assign req_ready = count_q != CW'(DEPTH);
    assign push      = req_valid && req_ready && !flush;
    assign core_x1   = x1_q[rd_q];
    assign core_x2   = x2_q[rd_q];
    assign core_y    = y_q[rd_q];
    assign core_op   = op_q[rd_q];
    assign core_data = dat_q[rd_q];
    // Hazard uses the start-of-cycle map, so a same-cycle completion only unblocks the head next cycle.
    assign hazard     = pend_q[core_x1] | pend_q[core_x2] | pend_q[core_y];
    assign core_valid = (count_q != '0) && !hazard && (infl_q < IW'(MAX_INFLIGHT)) && !flush;
    assign pop        = core_valid && core_ready;
    assign cpl_ok     = cpl_valid && pend_q[cpl_y];
    assign count      = count_q;
    assign inflight   = infl_q;
    assign pend_map   = pend_q;
    assign err_cpl    = err_q;

    always_comb begin
        pend_d  = (pend_q | (pop ? NR'(1) << core_y : '0)) & ~(cpl_ok ? NR'(1) << cpl_y : '0);
        infl_d  = infl_q + IW'(pop) - IW'(cpl_ok);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
        wr_d    = flush ? '0 : wr_q + PW'(push);
        rd_d    = flush ? '0 : rd_q + PW'(pop);
        err_d   = cpl_valid && !pend_q[cpl_y];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            infl_q  <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            infl_q  <= infl_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            x1_q[wr_q]  <= req_x1;
            x2_q[wr_q]  <= req_x2;
            y_q[wr_q]   <= req_y;
            op_q[wr_q]  <= req_op;
            dat_q[wr_q] <= req_data;
        end
    end
endmodule

// File: tb/tb_fpu_issue_buffer.sv
// tb_fpu_issue_buffer: directed-vector bench for fpu_issue_buffer with immediate-assertion checks.
module tb_fpu_issue_buffer;
    logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [4:0]  req_x1 = '0, req_x2 = '0, req_y = '0;
    logic [5:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic        core_valid, core_ready = 1'b0;
    logic [4:0]  core_x1, core_x2, core_y;
    logic [5:0]  core_op;
    logic [31:0] core_data;
    logic        cpl_valid = 1'b0;
    logic [4:0]  cpl_y = '0;
    logic [2:0]  count;
    logic [2:0]  inflight;
    logic [31:0] pend_map;
    logic        err_cpl;
    int          total = 0, passed = 0;

    fpu_issue_buffer dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_y(req_y), .req_op(req_op), .req_data(req_data),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_x1(core_x1), .core_x2(core_x2), .core_y(core_y), .core_op(core_op), .core_data(core_data),
        .cpl_valid(cpl_valid), .cpl_y(cpl_y),
        .count(count), .inflight(inflight), .pend_map(pend_map), .err_cpl(err_cpl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] y, input logic [4:0] x1, input logic [4:0] x2, input logic [31:0] d);
        req_valid = 1'b1;
        req_y = y; req_x1 = x1; req_x2 = x2; req_op = 6'h2A; req_data = d;
        tick();
        req_valid = 1'b0;
        #1;
    endtask

    task automatic cpl(input logic [4:0] y);
        cpl_valid = 1'b1;
        cpl_y = y;
        tick();
        cpl_valid = 1'b0;
        #1;
    endtask

    initial begin
        #12;
        check("rst_count", count, 0);
        check("rst_inflight", inflight, 0);
        check("rst_pend", pend_map, 0);
        check("rst_err", err_cpl, 0);
        check("rst_core_valid", core_valid, 0);
        check("rst_req_ready", req_ready, 1);
        rstn = 1'b1;
        tick();
        // basic push and issue
        enq(5'd3, 5'd1, 5'd2, 32'h3F800000);
        check("t1_valid", core_valid, 1);
        check("t1_x1", core_x1, 1);
        check("t1_x2", core_x2, 2);
        check("t1_y", core_y, 3);
        check("t1_op", core_op, 6'h2A);
        check("t1_data", core_data, 32'h3F800000);
        check("t1_count", count, 1);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        #1;
        check("t1_pend", pend_map, 32'h8);
        check("t1_infl", inflight, 1);
        check("t1_count0", count, 0);
        // RAW hazard
        enq(5'd5, 5'd0, 5'd0, 32'h1);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        #1;
        check("raw_pend", pend_map, 32'h28);
        enq(5'd6, 5'd5, 5'd0, 32'h2);
        check("raw_blocked", core_valid, 0);
        cpl_valid = 1'b1; cpl_y = 5'd5;
        #1;
        check("raw_blocked_cpl_cycle", core_valid, 0);
        tick();
        cpl_valid = 1'b0;
        #1;
        check("raw_pend_clr", pend_map, 32'h8);
        check("raw_infl", inflight, 1);
        check("raw_valid", core_valid, 1);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        #1;
        check("raw_issued_pend", pend_map, 32'h48);
        check("raw_issued_infl", inflight, 2);
        cpl(5'd3);
        cpl(5'd6);
        check("clr_pend", pend_map, 0);
        check("clr_infl", inflight, 0);
        // fill FIFO
        enq(5'd10, 5'd0, 5'd0, 32'h10);
        enq(5'd11, 5'd0, 5'd0, 32'h11);
        enq(5'd12, 5'd0, 5'd0, 32'h12);
        enq(5'd13, 5'd0, 5'd0, 32'h13);
        check("full_count", count, 4);
        check("full_ready", req_ready, 0);
        req_valid = 1'b1; req_y = 5'd14;
        tick();
        req_valid = 1'b0;
        #1;
        check("full_no_accept", count, 4);
        check("full_head", core_y, 10);
        core_ready = 1'b1;
        tick();
        #1;
        check("full_deq_count", count, 3);
        check("full_ready_back", req_ready, 1);
        tick();
        tick();
        tick();
        #1;
        check("max_infl", inflight, 4);
        check("max_pend", pend_map, 32'h3C00);
        enq(5'd14, 5'd0, 5'd0, 32'h14);
        check("max_blocked", core_valid, 0);
        check("max_count", count, 1);
        cpl(5'd11);
        check("max_cpl_infl", inflight, 3);
        check("max_valid", core_valid, 1);
        tick();
        core_ready = 1'b0;
        #1;
        check("max_reissue_infl", inflight, 4);
        check("max_reissue_pend", pend_map, 32'h7400);
        // spurious completion
        cpl(5'd9);
        check("err_pulse", err_cpl, 1);
        check("err_infl", inflight, 4);
        check("err_pend", pend_map, 32'h7400);
        tick();
        check("err_low", err_cpl, 0);
        // issue and completion in the same cycle
        enq(5'd20, 5'd0, 5'd0, 32'h20);
        cpl(5'd10);
        check("sc_valid", core_valid, 1);
        core_ready = 1'b1; cpl_valid = 1'b1; cpl_y = 5'd12;
        tick();
        core_ready = 1'b0; cpl_valid = 1'b0;
        #1;
        check("sc_infl", inflight, 3);
        check("sc_pend", pend_map, 32'h106000);
        check("sc_count", count, 0);
        cpl(5'd13);
        cpl(5'd14);
        cpl(5'd20);
        check("sc_pend0", pend_map, 0);
        // flush
        enq(5'd7, 5'd0, 5'd0, 32'h7);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        #1;
        enq(5'd21, 5'd0, 5'd0, 32'h21);
        enq(5'd22, 5'd0, 5'd0, 32'h22);
        enq(5'd23, 5'd0, 5'd0, 32'h23);
        check("fl_count3", count, 3);
        flush = 1'b1; req_valid = 1'b1; req_y = 5'd24; core_ready = 1'b1;
        #1;
        check("fl_core_valid", core_valid, 0);
        tick();
        flush = 1'b0; req_valid = 1'b0; core_ready = 1'b0;
        #1;
        check("fl_count", count, 0);
        check("fl_valid", core_valid, 0);
        check("fl_pend", pend_map, 32'h80);
        check("fl_infl", inflight, 1);
        cpl(5'd7);
        check("fl_cpl_pend", pend_map, 0);
        check("fl_cpl_infl", inflight, 0);
        // simultaneous enqueue and issue
        core_ready = 1'b1; req_valid = 1'b1; req_y = 5'd24; req_x1 = 5'd0; req_x2 = 5'd0;
        tick();
        req_y = 5'd25;
        tick();
        req_valid = 1'b0; core_ready = 1'b0;
        #1;
        check("tp_count", count, 1);
        check("tp_infl", inflight, 1);
        check("tp_pend", pend_map, 32'h1000000);
        check("tp_head", core_y, 25);
        // asynchronous reset mid-operation
        #2;
        rstn = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_infl", inflight, 0);
        check("ar_pend", pend_map, 0);
        check("ar_valid", core_valid, 0);
        check("ar_ready", req_ready, 1);
        rstn = 1'b1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
